rsa_exp_sequencer: RTL and testbench

//   Sequences y^d mod N for the RSA decrypt core by driving one modular-prep unit
//   (computes y*2^256 mod N) and one time-shared Montgomery multiplier. The single

---
 rtl/rsa_exp_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_rsa_exp_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_exp_sequencer.sv
`timescale 1ns/1ps
// rsa_exp_sequencer: right-to-left square-and-multiply controller for y^d mod N.
// m stays in the plain domain (starts at 1), t holds y^(2^k) in Montgomery form.
// The prep unit supplies t = y*2^WIDTH mod N. One Montgomery multiplier is
// time-shared between the conditional product and the per-bit square.
module rsa_exp_sequencer #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned CNT_W = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_y,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_result,
    output logic             o_finished,
    output logic             o_busy,
    output logic             o_prep_start,
    output logic [WIDTH:0]   o_prep_n,
    output logic [WIDTH:0]   o_prep_a,
    output logic [WIDTH:0]   o_prep_b,
    output logic [CNT_W-1:0] o_prep_k,
    input  logic [WIDTH-1:0] i_prep_m,
    input  logic             i_prep_done,
    output logic             o_mont_start,
    output logic [WIDTH:0]   o_mont_n,
    output logic [WIDTH:0]   o_mont_a,
    output logic [WIDTH:0]   o_mont_b,
    input  logic [WIDTH-1:0] i_mont_m,
    input  logic             i_mont_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_MUL_ISSUE,
        S_MUL_WAIT,
        S_SQR_ISSUE,
        S_SQR_WAIT,
        S_DONE
    } state_t;

    localparam logic [WIDTH:0] PREP_A = {1'b1, {WIDTH{1'b0}}};

    state_t           state, state_nxt;
    logic [WIDTH-1:0] n_r, y_r, d_r, t, m, result, mont_a, mont_b;
    logic [WIDTH-1:0] n_nxt, y_nxt, d_nxt, t_nxt, m_nxt, result_nxt, mont_a_nxt, mont_b_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             finished, busy, prep_start, mont_start;
    logic             finished_nxt, busy_nxt, prep_start_nxt, mont_start_nxt;
    logic             d_bit;

    // Current exponent bit, scanned LSB first.
    assign d_bit = |(d_r & (WIDTH'(1) << cnt));

    // State and datapath registers; all pulses and operands leave the block registered.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= S_IDLE;
            n_r        <= '0;
            y_r        <= '0;
            d_r        <= '0;
            t          <= '0;
            m          <= '0;
            result     <= '0;
            mont_a     <= '0;
            mont_b     <= '0;
            cnt        <= '0;
            finished   <= 1'b0;
            busy       <= 1'b0;
            prep_start <= 1'b0;
            mont_start <= 1'b0;
        end else begin
            state      <= state_nxt;
            n_r        <= n_nxt;
            y_r        <= y_nxt;
            d_r        <= d_nxt;
            t          <= t_nxt;
            m          <= m_nxt;
            result     <= result_nxt;
            mont_a     <= mont_a_nxt;
            mont_b     <= mont_b_nxt;
            cnt        <= cnt_nxt;
            finished   <= finished_nxt;
            busy       <= busy_nxt;
            prep_start <= prep_start_nxt;
            mont_start <= mont_start_nxt;
        end
    end

    // Next-state and next-register values; done pulses outside the matching wait state are dropped.
    always_comb begin
        state_nxt      = state;
        n_nxt          = n_r;
        y_nxt          = y_r;
        d_nxt          = d_r;
        t_nxt          = t;
        m_nxt          = m;
        result_nxt     = result;
        mont_a_nxt     = mont_a;
        mont_b_nxt     = mont_b;
        cnt_nxt        = cnt;
        finished_nxt   = 1'b0;
        prep_start_nxt = 1'b0;
        mont_start_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    n_nxt          = i_n;
                    y_nxt          = i_y;
                    d_nxt          = i_d;
                    m_nxt          = WIDTH'(1);
                    cnt_nxt        = '0;
                    prep_start_nxt = 1'b1;
                    state_nxt      = S_PREP;
                end
            end
            S_PREP: begin
                if (i_prep_done) begin
                    t_nxt     = i_prep_m;
                    state_nxt = S_MUL_ISSUE;
                end
            end
            S_MUL_ISSUE: begin
                if (d_bit) begin
                    mont_a_nxt     = m;
                    mont_b_nxt     = t;
                    mont_start_nxt = 1'b1;
                    state_nxt      = S_MUL_WAIT;
                end else begin
                    state_nxt = S_SQR_ISSUE;
                end
            end
            S_MUL_WAIT: begin
                if (i_mont_done) begin
                    m_nxt     = i_mont_m;
                    state_nxt = S_SQR_ISSUE;
                end
            end
            S_SQR_ISSUE: begin
                mont_a_nxt     = t;
                mont_b_nxt     = t;
                mont_start_nxt = 1'b1;
                state_nxt      = S_SQR_WAIT;
            end
            S_SQR_WAIT: begin
                if (i_mont_done) begin
                    t_nxt = i_mont_m;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        // Result and finished are loaded so both are visible during S_DONE.
                        result_nxt   = m;
                        finished_nxt = 1'b1;
                        state_nxt    = S_DONE;
                    end else begin
                        cnt_nxt   = cnt + CNT_W'(1);
                        state_nxt = S_MUL_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    assign o_result     = result;
    assign o_finished   = finished;
    assign o_busy       = busy;
    assign o_prep_start = prep_start;
    assign o_prep_n     = {1'b0, n_r};
    assign o_prep_a     = PREP_A;
    assign o_prep_b     = {1'b0, y_r};
    assign o_prep_k     = CNT_W'(WIDTH);
    assign o_mont_start = mont_start;
    assign o_mont_n     = {1'b0, n_r};
    assign o_mont_a     = {1'b0, mont_a};
    assign o_mont_b     = {1'b0, mont_b};

endmodule

// File: tb/tb_rsa_exp_sequencer.sv
`timescale 1ns/1ps
// Bench for rsa_exp_sequencer: behavioural prep and Montgomery units with variable
// latency, a vector table of modexp jobs and directed multi-cycle corner cases.
module tb_rsa_exp_sequencer;
    localparam int unsigned W         = 256;
    localparam int unsigned CW        = 9;
    localparam int unsigned NV        = 26;
    localparam int unsigned JOB_LIMIT = 30000;
    localparam logic [W:0]  PREP_A    = {1'b1, {W{1'b0}}};

    typedef struct {
        logic [W-1:0] n;
        logic [W-1:0] y;
        logic [W-1:0] d;
        logic [W-1:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  y_in = '0, d_in = '0, n_in = '0;
    logic [W-1:0]  result;
    logic          finished, busy;
    logic          prep_start, mont_start;
    logic [W:0]    prep_n, prep_a, prep_b, mont_n, mont_a, mont_b;
    logic [CW-1:0] prep_k;
    logic [W-1:0]  prep_m = '0, mont_m = '0;
    logic          prep_done = 1'b0, mont_done = 1'b0;

    int unsigned pass_cnt = 0, total_cnt = 0;
    int unsigned mont_starts = 0, sq_starts = 0, prep_starts = 0, fin_cnt = 0;
    int unsigned mont_dones = 0, proto_err = 0;
    int unsigned lat_fixed = 0;

    logic         mont_busy = 1'b0, mont_stale = 1'b0, last_sq = 1'b0;
    int unsigned  mont_left = 0;
    logic [W-1:0] mont_res = '0;
    logic [W:0]   mont_a_cap = '0, mont_b_cap = '0;
    logic         prep_busy = 1'b0;
    int unsigned  prep_left = 0;
    logic [W-1:0] prep_res = '0;

    vec_t vecs [NV];

    rsa_exp_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_y(y_in), .i_d(d_in), .i_n(n_in),
        .o_result(result), .o_finished(finished), .o_busy(busy),
        .o_prep_start(prep_start), .o_prep_n(prep_n), .o_prep_a(prep_a),
        .o_prep_b(prep_b), .o_prep_k(prep_k),
        .i_prep_m(prep_m), .i_prep_done(prep_done),
        .o_mont_start(mont_start), .o_mont_n(mont_n), .o_mont_a(mont_a),
        .o_mont_b(mont_b), .i_mont_m(mont_m), .i_mont_done(mont_done)
    );

    always #5 clk = ~clk;

    // Bit-serial Montgomery reduction: a*b*2^-W mod n.
    function automatic logic [W-1:0] mont_ref(input logic [W:0] a, input logic [W:0] b,
                                               input logic [W:0] n);
        logic [W+2:0] u;
        u = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (a[i]) u = u + {2'b00, b};
            if (u[0]) u = u + {2'b00, n};
            u = u >> 1;
        end
        if (u >= {2'b00, n}) u = u - {2'b00, n};
        return u[W-1:0];
    endfunction

    // Plain square-and-multiply with full-width modular reduction.
    function automatic logic [W-1:0] modexp(input logic [W-1:0] y, input logic [W-1:0] d,
                                             input logic [W-1:0] n);
        logic [2*W-1:0] r, b, nn;
        r = '0; r[0] = 1'b1;
        b = {{W{1'b0}}, y};
        nn = {{W{1'b0}}, n};
        for (int unsigned i = 0; i < W; i++) begin
            if (d[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[W-1:0];
    endfunction

    function automatic int unsigned pick_lat();
        if (lat_fixed != 0) return lat_fixed;
        if ($urandom_range(0, 255) == 0) return $urandom_range(1, 300);
        return $urandom_range(1, 2);
    endfunction

    // Montgomery unit model plus request-protocol monitor.
    always @(negedge clk) begin
        mont_done = 1'b0;
        if (!rst) mont_stale = 1'b1;
        if (mont_busy) begin
            if (rst && !mont_stale && (mont_a != mont_a_cap || mont_b != mont_b_cap)) proto_err++;
            if (mont_left == 0) begin
                mont_done = 1'b1;
                mont_m    = mont_res;
                mont_busy = 1'b0;
                mont_dones++;
            end else begin
                mont_left--;
            end
        end
        if (mont_start) begin
            mont_starts++;
            last_sq = (mont_a == mont_b);
            if (last_sq) sq_starts++;
            if (mont_busy || mont_a[W] || mont_b[W] || mont_n[W]) proto_err++;
            mont_res   = mont_ref(mont_a, mont_b, mont_n);
            mont_a_cap = mont_a;
            mont_b_cap = mont_b;
            mont_left  = pick_lat() - 1;
            mont_busy  = 1'b1;
            mont_stale = 1'b0;
        end
    end

    // Prep unit model: b*2^k mod n.
    always @(negedge clk) begin
        prep_done = 1'b0;
        if (prep_busy) begin
            if (prep_left == 0) begin
                prep_done = 1'b1;
                prep_m    = prep_res;
                prep_busy = 1'b0;
            end else begin
                prep_left--;
            end
        end
        if (prep_start) begin
            prep_starts++;
            if (prep_busy || prep_a != PREP_A || prep_k != CW'(W) || prep_n[W] || prep_b[W])
                proto_err++;
            prep_res  = W'(({prep_b[W-1:0], {W{1'b0}}}) % {{(W-1){1'b0}}, prep_n});
            prep_left = $urandom_range(1, 300) - 1;
            prep_busy = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (finished) fin_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic wait_units_idle();
        int unsigned c;
        c = 0;
        while ((mont_busy || prep_busy) && c < JOB_LIMIT) begin tick(); c++; end
        check("units_idle_before_start", W'(mont_busy | prep_busy), '0);
    endtask

    task automatic pulse_start(input logic [W-1:0] n, input logic [W-1:0] y, input logic [W-1:0] d);
        n_in = n; y_in = y; d_in = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_finished(input string name);
        int unsigned c;
        c = 0;
        while (!finished && c < JOB_LIMIT) begin tick(); c++; end
        check({name, "_finished_in_budget"}, W'(finished), W'(1));
    endtask

    task automatic run_job(input string name, input vec_t v);
        int unsigned ms0, sq0, pr0, fn0, pe0;
        wait_units_idle();
        ms0 = mont_starts; sq0 = sq_starts; pr0 = prep_starts; fn0 = fin_cnt; pe0 = proto_err;
        pulse_start(v.n, v.y, v.d);
        check({name, "_busy_after_start"}, W'(busy), W'(1));
        wait_finished(name);
        check({name, "_result"}, result, v.exp);
        check({name, "_busy_in_done"}, W'(busy), W'(1));
        tick();
        check({name, "_finished_one_cycle"}, W'(fin_cnt - fn0), W'(1));
        check({name, "_idle_after_done"}, W'(busy), '0);
        check({name, "_result_held"}, result, v.exp);
        check({name, "_mont_starts"}, W'(mont_starts - ms0), W'(W + $countones(v.d)));
        check({name, "_squares"}, W'(sq_starts - sq0) >= W'(W) ? W'(1) : '0, W'(1));
        check({name, "_prep_starts"}, W'(prep_starts - pr0), W'(1));
        check({name, "_protocol"}, W'(proto_err - pe0), '0);
    endtask

    initial begin
        logic [W-1:0] big_n, r;
        int unsigned ms0, sq0, fn0, md0, c, held_bad;

        // Hand-computed vectors (2^256 mod 33 = 31; 4 has order 5 mod 33).
        vecs[0] = '{n: W'(33), y: W'(4), d: W'(3),  exp: W'(31)};
        vecs[1] = '{n: W'(33), y: W'(4), d: W'(0),  exp: W'(1)};
        vecs[2] = '{n: W'(33), y: W'(5), d: W'(2),  exp: W'(25)};
        vecs[3] = '{n: W'(35), y: W'(2), d: W'(10), exp: W'(9)};
        vecs[4] = '{n: W'(33), y: W'(0), d: W'(5),  exp: W'(0)};
        vecs[5] = '{n: W'(33), y: W'(4), d: {1'b1, {(W-1){1'b0}}}, exp: W'(31)};
        big_n = '1;
        big_n[3:0] = 4'h1;
        for (int unsigned i = 6; i < NV; i++) begin
            vecs[i].n = big_n;
            for (int unsigned k = 0; k < W / 32; k++) begin
                vecs[i].y[k*32 +: 32] = $urandom();
                vecs[i].d[k*32 +: 32] = $urandom();
            end
            if (vecs[i].y >= big_n) vecs[i].y = vecs[i].y - big_n;
            vecs[i].exp = modexp(vecs[i].y, vecs[i].d, vecs[i].n);
        end
        vecs[NV-1].d = '1;
        vecs[NV-1].exp = modexp(vecs[NV-1].y, vecs[NV-1].d, vecs[NV-1].n);

        // Reset state.
        rst = 1'b0;
        repeat (3) tick();
        check("rst_result", result, '0);
        check("rst_finished", W'(finished), '0);
        check("rst_busy", W'(busy), '0);
        check("rst_prep_start", W'(prep_start), '0);
        check("rst_mont_start", W'(mont_start), '0);
        rst = 1'b1;
        tick();

        for (int unsigned i = 0; i < NV; i++) begin
            run_job($sformatf("vec%0d", i), vecs[i]);
        end

        // Exactly 256 squares and 2 products for d=3, 256 squares only for d=0.
        wait_units_idle();
        ms0 = mont_starts; sq0 = sq_starts;
        pulse_start(W'(33), W'(4), W'(3));
        wait_finished("sq_d3");
        check("sq_d3_squares", W'(sq_starts - sq0), W'(256));
        check("sq_d3_products", W'((mont_starts - ms0) - (sq_starts - sq0)), W'(2));
        tick();
        ms0 = mont_starts; sq0 = sq_starts;
        pulse_start(W'(33), W'(4), W'(0));
        wait_finished("sq_d0");
        check("sq_d0_squares", W'(sq_starts - sq0), W'(256));
        check("sq_d0_products", W'((mont_starts - ms0) - (sq_starts - sq0)), '0);
        tick();

        // Second start while a square is outstanding must be ignored.
        wait_units_idle();
        lat_fixed = 8;
        ms0 = mont_starts; fn0 = fin_cnt;
        pulse_start(W'(33), W'(4), W'(3));
        c = 0;
        while (!(mont_busy && last_sq && (mont_starts - ms0) >= 4) && c < JOB_LIMIT) begin
            tick(); c++;
        end
        check("busy_start_reached_sqr_wait", W'(mont_busy && last_sq), W'(1));
        pulse_start(W'(33), W'(5), W'(7));
        wait_finished("busy_start");
        check("busy_start_result", result, W'(31));
        check("busy_start_mont_starts", W'(mont_starts - ms0), W'(258));
        tick();
        check("busy_start_one_finish", W'(fin_cnt - fn0), W'(1));
        lat_fixed = 0;

        // Back-to-back: start in the cycle right after o_finished.
        wait_units_idle();
        pulse_start(W'(33), W'(4), W'(3));
        wait_finished("b2b_first");
        check("b2b_first_result", result, W'(31));
        tick();
        fn0 = fin_cnt;
        pulse_start(W'(33), W'(5), W'(2));
        check("b2b_second_accepted", W'(busy), W'(1));
        held_bad = 0;
        c = 0;
        while (!finished && c < JOB_LIMIT) begin
            if (result != W'(31)) held_bad++;
            tick(); c++;
        end
        check("b2b_old_result_held", W'(held_bad), '0);
        check("b2b_second_result", result, W'(25));
        tick();
        check("b2b_second_finish_once", W'(fin_cnt - fn0), W'(1));

        // Reset while waiting on a product; the late done must not revive the FSM.
        wait_units_idle();
        lat_fixed = 50;
        ms0 = mont_starts;
        pulse_start(W'(33), W'(4), W'(3));
        c = 0;
        while (!(mont_busy && !last_sq) && c < JOB_LIMIT) begin tick(); c++; end
        check("rst_mid_in_mul_wait", W'(mont_busy && !last_sq), W'(1));
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        ms0 = mont_starts; fn0 = fin_cnt; md0 = mont_dones;
        repeat (80) tick();
        check("rst_mid_late_done_seen", W'(mont_dones - md0), W'(1));
        check("rst_mid_no_mont_start", W'(mont_starts - ms0), '0);
        check("rst_mid_no_finish", W'(fin_cnt - fn0), '0);
        check("rst_mid_result_zero", result, '0);
        check("rst_mid_idle", W'(busy), '0);
        lat_fixed = 0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
